inst_mem_loader: RTL and testbench
==================================

# inst_mem_loader

Host-side writer for the per-PE instruction memories of the SCGRA array. It accepts a stream of 32-bit host words and packs every three words into one 72-bit instruction. Each packed instruction is written to a contiguous address range in the instruction memory of one selected PE, or of all PEs. Loading is refused while the array is executing (PE_Array_Busy), so the instruction sequencers in the PEs never read a memory that is being rewritten.

## Interface
Parameters:
- INST_DWIDTH, 72, instruction width; must satisfy 64 < INST_DWIDTH <= 96.
- INST_AWIDTH, 10, instruction memory address width; depth is 2^INST_AWIDTH.
- HWIDTH, 32, host word width.
- PE_NUM, 4, number of PEs.
- PE_SELW, 3, width of Load_PE_Sel.

Ports:
- Clk  in  1  clock.
- Resetn  in  1  reset, asynchronous, active-low.
- Load_Start  in  1  one-cycle request pulse; sampled only in IDLE.
- Load_Base  in  INST_AWIDTH  first instruction address.
- Load_Len  in  INST_AWIDTH+1  number of instructions, 1..2^INST_AWIDTH.
- Load_PE_Sel  in  PE_SELW  target PE index; value PE_NUM means broadcast to all PEs; values above PE_NUM are an error.
- PE_Array_Busy  in  1  the array is executing.
- Host_Data  in  HWIDTH  stream data.
- Host_Valid  in  1  stream valid.
- Host_Ready  out  1  stream ready; registered.
- Inst_Wr_En  out  PE_NUM  per-PE write strobe.
- Inst_Wr_Addr  out  INST_AWIDTH  write address.
- Inst_Wr_Data  out  INST_DWIDTH  packed instruction.
- Load_Busy  out  1  high while state != IDLE.
- Load_Done  out  1  one-cycle completion pulse.
- Load_Err  out  1  one-cycle rejection pulse.

## Operation
- States: IDLE, LOAD, WRITE, DONE. All outputs are registered and reset to 0; the state resets to IDLE.
- **IDLE, on Load_Start = 1:**
  - Error checks: PE_Array_Busy = 1, Load_Len = 0, Load_Base + Load_Len > 2^INST_AWIDTH (computed at INST_AWIDTH+2 bits, so no wrap), or Load_PE_Sel > PE_NUM.
  - If any check fails: pulse Load_Err and stay in IDLE.
  - Otherwise: latch base, length and select; clear the beat counter; go to LOAD.
- **LOAD:**
  - Host_Ready = 1.
  - A beat is accepted when Host_Valid && Host_Ready are both high at a rising edge.
  - Beat 0 goes to bits [31:0], beat 1 to [63:32], and beat 2 bits [INST_DWIDTH-65:0] to [INST_DWIDTH-1:64]. The upper bits of beat 2 are discarded.
  - After beat 2 is accepted, go to WRITE.
  - Host_Valid low stalls indefinitely; no timeout.
- **WRITE (exactly one cycle):**
  - Inst_Wr_En = one-hot(select), or all ones for broadcast.
  - Inst_Wr_Addr = current address; Inst_Wr_Data = packed word.
  - Host_Ready = 0.
  - Then decrement the remaining count and increment the address. Go to LOAD if the remaining count is nonzero, else go to DONE.
- **DONE (one cycle):** Load_Done = 1, then go to IDLE.
- Inst_Wr_En is 0 outside WRITE. Inst_Wr_Addr and Inst_Wr_Data hold their last value.
- PE_Array_Busy is checked only at start. If it rises mid-load, the load continues; system control forbids this case.
- Load_Start outside IDLE is ignored: no error, no effect.
- Asynchronous reset mid-load: state goes to IDLE and every output goes to 0 immediately. The partial instruction is discarded. Instructions already written stay written.

## Timing
- Start accepted at edge T: Load_Busy = 1 and Host_Ready = 1 from T.
- Third beat accepted at edge E:
  - Host_Ready = 0 and Inst_Wr_En active from E for one cycle.
  - At E+1, Host_Ready returns to 1 if more instructions remain.
- Throughput: 4 cycles per instruction with Host_Valid held high.
- Total cycles from start to Load_Done: 4·Load_Len + 1 with continuous valid. Load_Done is high in cycle T+4·Load_Len. Load_Busy falls together with Load_Done at the following edge.
- Load_Err is asserted at the edge after the rejected start and lasts one cycle.
- Back-to-back: a new Load_Start is accepted in the first IDLE cycle after DONE.

## Test plan
- Base 0, Len 2, PE_Sel 1, valid always high, words 0x11111111, 0x22222222, 0x000000AB, 0x33333333, 0x44444444, 0xFFFFFFCD:
  - Inst_Wr_En = 4'b0010 at addr 0 with data 0xAB_22222222_11111111.
  - Inst_Wr_En = 4'b0010 at addr 1 with data 0xCD_44444444_33333333.
  - Load_Done pulses 9 cycles after start.
- Broadcast: PE_Sel = 4, Len 1 -> Inst_Wr_En = 4'b1111 for exactly one cycle.
- Range and busy errors:
  - Base 1020, Len 5 -> Load_Err pulse, no writes, Load_Busy stays 0.
  - Len 0 -> Load_Err.
  - PE_Sel = 5 -> Load_Err.
  - PE_Array_Busy = 1 at start -> Load_Err.
- Boundary: Base 1023, Len 1 -> a single write at addr 1023, Load_Done, no error.
- Host_Valid toggled randomly over 3 instructions -> data packed correctly, no beat lost or duplicated, Host_Ready low during each WRITE cycle.
- Resetn pulsed low after beat 1 of instruction 2:
  - All outputs read 0 immediately; no write of the partial instruction.
  - A subsequent load with Base 0, Len 1 completes normally.

Source files
------------

// File: rtl/inst_mem_loader.sv
// ============================================================================
// inst_mem_loader : packs 3 host words per instruction and writes them into
// one or all PE instruction memories.            Revision: 1.0
// ============================================================================
`default_nettype none

module inst_mem_loader #(
   parameter int INST_DWIDTH = 72,
   parameter int INST_AWIDTH = 10,
   parameter int HWIDTH      = 32,
   parameter int PE_NUM      = 4,
   parameter int PE_SELW     = 3
) (
   input  logic                     Clk,
   input  logic                     Resetn,
   input  logic                     Load_Start,
   input  logic [INST_AWIDTH-1:0]   Load_Base,
   input  logic [INST_AWIDTH:0]     Load_Len,
   input  logic [PE_SELW-1:0]       Load_PE_Sel,
   input  logic                     PE_Array_Busy,
   input  logic [HWIDTH-1:0]        Host_Data,
   input  logic                     Host_Valid,
   output logic                     Host_Ready,
   output logic [PE_NUM-1:0]        Inst_Wr_En,
   output logic [INST_AWIDTH-1:0]   Inst_Wr_Addr,
   output logic [INST_DWIDTH-1:0]   Inst_Wr_Data,
   output logic                     Load_Busy,
   output logic                     Load_Done,
   output logic                     Load_Err
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [INST_AWIDTH+1:0] DEPTH     = (INST_AWIDTH+2)'(1) << INST_AWIDTH;
   localparam logic [PE_SELW-1:0]     SEL_BCAST = PE_SELW'(PE_NUM);
   localparam logic [PE_NUM-1:0]      PE_ONE    = PE_NUM'(1);
   localparam logic [INST_AWIDTH:0]   LEN_ONE   = (INST_AWIDTH+1)'(1);

   state_t                    state_q, state_d;
   logic [INST_AWIDTH-1:0]    addr_q, addr_d;
   logic [INST_AWIDTH:0]      rem_q, rem_d;
   logic [PE_SELW-1:0]        sel_q, sel_d;
   logic [1:0]                beat_q, beat_d;
   logic [2*HWIDTH-1:0]       lo_q, lo_d;
   logic                      ready_q, ready_d;
   logic [PE_NUM-1:0]         wr_en_q, wr_en_d;
   logic [INST_AWIDTH-1:0]    wr_addr_q, wr_addr_d;
   logic [INST_DWIDTH-1:0]    wr_data_q, wr_data_d;
   logic                      busy_q, busy_d;
   logic                      done_q, done_d;
   logic                      err_q, err_d;

   logic [INST_AWIDTH+1:0]    end_sum;
   logic                      start_bad;
   logic [PE_NUM-1:0]         pe_mask;

   // End address checked two bits wider than the address so it cannot wrap.
   assign end_sum   = {2'b00, Load_Base} + {1'b0, Load_Len};
   assign start_bad = PE_Array_Busy || (Load_Len == '0) || (end_sum > DEPTH)
                      || (Load_PE_Sel > SEL_BCAST);
   assign pe_mask   = (sel_q == SEL_BCAST) ? '1 : (PE_ONE << sel_q);

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      rem_d     = rem_q;
      sel_d     = sel_q;
      beat_d    = beat_q;
      lo_d      = lo_q;
      ready_d   = 1'b0;
      wr_en_d   = '0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (Load_Start) begin
               if (start_bad) begin
                  err_d = 1'b1;
               end else begin
                  state_d = S_LOAD;
                  addr_d  = Load_Base;
                  rem_d   = Load_Len;
                  sel_d   = Load_PE_Sel;
                  beat_d  = 2'd0;
                  ready_d = 1'b1;
               end
            end
         end
         S_LOAD: begin
            ready_d = 1'b1;
            if (Host_Valid && ready_q) begin
               case (beat_q)
                  2'd0: begin
                     lo_d[HWIDTH-1:0] = Host_Data;
                     beat_d           = 2'd1;
                  end
                  2'd1: begin
                     lo_d[2*HWIDTH-1:HWIDTH] = Host_Data;
                     beat_d                  = 2'd2;
                  end
                  default: begin
                     // Third beat: only its low bits fit above the first two words.
                     wr_en_d   = pe_mask;
                     wr_addr_d = addr_q;
                     wr_data_d = {Host_Data[INST_DWIDTH-2*HWIDTH-1:0], lo_q};
                     ready_d   = 1'b0;
                     beat_d    = 2'd0;
                     state_d   = S_WRITE;
                  end
               endcase
            end
         end
         S_WRITE: begin
            rem_d  = rem_q - LEN_ONE;
            addr_d = addr_q + 1'b1;
            if (rem_q != LEN_ONE) begin
               state_d = S_LOAD;
               ready_d = 1'b1;
            end else begin
               state_d = S_DONE;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge Clk or negedge Resetn) begin
      if (!Resetn) begin
         state_q   <= S_IDLE;
         addr_q    <= '0;
         rem_q     <= '0;
         sel_q     <= '0;
         beat_q    <= '0;
         lo_q      <= '0;
         ready_q   <= 1'b0;
         wr_en_q   <= '0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         rem_q     <= rem_d;
         sel_q     <= sel_d;
         beat_q    <= beat_d;
         lo_q      <= lo_d;
         ready_q   <= ready_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   assign Host_Ready   = ready_q;
   assign Inst_Wr_En   = wr_en_q;
   assign Inst_Wr_Addr = wr_addr_q;
   assign Inst_Wr_Data = wr_data_q;
   assign Load_Busy    = busy_q;
   assign Load_Done    = done_q;
   assign Load_Err     = err_q;

endmodule

`default_nettype wire

// File: tb/tb_inst_mem_loader.sv
// ============================================================================
// tb_inst_mem_loader : randomized loads checked against a queue-based model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_inst_mem_loader;

   localparam int DW  = 72;
   localparam int AW  = 10;
   localparam int HW  = 32;
   localparam int NPE = 4;
   localparam int SW  = 3;

   logic           Clk = 1'b0;
   logic           Resetn = 1'b0;
   logic           Load_Start = 1'b0;
   logic [AW-1:0]  Load_Base = '0;
   logic [AW:0]    Load_Len = '0;
   logic [SW-1:0]  Load_PE_Sel = '0;
   logic           PE_Array_Busy = 1'b0;
   logic [HW-1:0]  Host_Data = '0;
   logic           Host_Valid = 1'b0;
   logic           Host_Ready;
   logic [NPE-1:0] Inst_Wr_En;
   logic [AW-1:0]  Inst_Wr_Addr;
   logic [DW-1:0]  Inst_Wr_Data;
   logic           Load_Busy;
   logic           Load_Done;
   logic           Load_Err;

   inst_mem_loader #(
      .INST_DWIDTH(DW), .INST_AWIDTH(AW), .HWIDTH(HW), .PE_NUM(NPE), .PE_SELW(SW)
   ) dut (
      .Clk(Clk), .Resetn(Resetn), .Load_Start(Load_Start), .Load_Base(Load_Base),
      .Load_Len(Load_Len), .Load_PE_Sel(Load_PE_Sel), .PE_Array_Busy(PE_Array_Busy),
      .Host_Data(Host_Data), .Host_Valid(Host_Valid), .Host_Ready(Host_Ready),
      .Inst_Wr_En(Inst_Wr_En), .Inst_Wr_Addr(Inst_Wr_Addr), .Inst_Wr_Data(Inst_Wr_Data),
      .Load_Busy(Load_Busy), .Load_Done(Load_Done), .Load_Err(Load_Err)
   );

   always #5 Clk = ~Clk;

   int cyc = 0;
   always @(posedge Clk) cyc <= cyc + 1;

   typedef struct packed {
      logic [NPE-1:0] en;
      logic [AW-1:0]  addr;
      logic [DW-1:0]  data;
   } wr_t;

   wr_t          exp_q[$];
   wr_t          seen[$];
   logic [31:0]  words[$];
   int           n_cmp = 0;
   int           n_bad = 0;

   task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp_v);
      n_cmp++;
      if (act !== exp_v) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp_v, $time);
      end
   endtask

   // Every write strobe must match the next instruction the model predicts.
   wr_t mon_w, mon_e;
   always @(negedge Clk) begin
      if (Inst_Wr_En !== '0) begin
         mon_w.en   = Inst_Wr_En;
         mon_w.addr = Inst_Wr_Addr;
         mon_w.data = Inst_Wr_Data;
         seen.push_back(mon_w);
         chk("ready_low_in_write", {95'd0, Host_Ready}, 96'd0);
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_write: got en=%0h addr=%0h, expected no write",
                     Inst_Wr_En, Inst_Wr_Addr);
         end else begin
            mon_e = exp_q.pop_front();
            chk("wr_en", {92'd0, mon_w.en}, {92'd0, mon_e.en});
            chk("wr_addr", {86'd0, mon_w.addr}, {86'd0, mon_e.addr});
            chk("wr_data", {24'd0, mon_w.data}, {24'd0, mon_e.data});
         end
      end
   end

   // Called at a falling edge; returns at a falling edge with the loader idle
   // (or, with nstop > 0, right after the nstop-th word has been accepted).
   task automatic do_load(input int base, input int len, input int sel,
                          input int prob, input int nstop);
      int   total, idx, t0, guard, ninst;
      logic acc;
      wr_t  x;
      total = 3 * len;
      if (words.size() == 0)
         for (int i = 0; i < total; i++) words.push_back($urandom);
      ninst = (nstop > 0) ? nstop / 3 : len;
      for (int i = 0; i < ninst; i++) begin
         x.en   = (sel == NPE) ? 4'hF : 4'(1 << sel);
         x.addr = AW'((base + i) % 1024);
         x.data = {words[3*i+2][7:0], words[3*i+1], words[3*i]};
         exp_q.push_back(x);
      end
      if (nstop > 0) total = nstop;
      Load_Start  = 1'b1;
      Load_Base   = AW'(base);
      Load_Len    = (AW+1)'(len);
      Load_PE_Sel = SW'(sel);
      @(posedge Clk);
      @(negedge Clk);
      Load_Start = 1'b0;
      t0 = cyc;
      chk("busy_at_start", {95'd0, Load_Busy}, 96'd1);
      chk("ready_at_start", {95'd0, Host_Ready}, 96'd1);
      idx = 0;
      guard = 0;
      while (idx < total) begin
         if (guard > 4000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL beat_timeout: got %0d words accepted, expected %0d", idx, total);
            break;
         end
         Host_Valid = ($urandom_range(1, 100) <= prob);
         Host_Data  = Host_Valid ? words[idx] : $urandom;
         acc = Host_Valid && Host_Ready;
         @(posedge Clk);
         if (acc) idx++;
         @(negedge Clk);
         guard++;
      end
      Host_Valid = 1'b0;
      words.delete();
      if (nstop > 0) return;
      guard = 0;
      while (!Load_Done && guard < 50) begin
         @(negedge Clk);
         guard++;
      end
      chk("load_done", {95'd0, Load_Done}, 96'd1);
      if (prob >= 100) chk("done_latency", 96'(cyc - t0), 96'(4 * len));
      @(negedge Clk);
      chk("done_one_cycle", {95'd0, Load_Done}, 96'd0);
      chk("busy_after_done", {95'd0, Load_Busy}, 96'd0);
   endtask

   task automatic do_err(input int base, input int len, input int sel, input logic busy);
      PE_Array_Busy = busy;
      Load_Start    = 1'b1;
      Load_Base     = AW'(base);
      Load_Len      = (AW+1)'(len);
      Load_PE_Sel   = SW'(sel);
      @(posedge Clk);
      @(negedge Clk);
      Load_Start    = 1'b0;
      PE_Array_Busy = 1'b0;
      chk("err_pulse", {95'd0, Load_Err}, 96'd1);
      chk("err_not_busy", {95'd0, Load_Busy}, 96'd0);
      chk("err_not_ready", {95'd0, Host_Ready}, 96'd0);
      @(negedge Clk);
      chk("err_one_cycle", {95'd0, Load_Err}, 96'd0);
      chk("err_still_idle", {95'd0, Load_Busy}, 96'd0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ready"}, {95'd0, Host_Ready}, 96'd0);
      chk({tag, "_wr_en"}, {92'd0, Inst_Wr_En}, 96'd0);
      chk({tag, "_wr_addr"}, {86'd0, Inst_Wr_Addr}, 96'd0);
      chk({tag, "_wr_data"}, {24'd0, Inst_Wr_Data}, 96'd0);
      chk({tag, "_busy"}, {95'd0, Load_Busy}, 96'd0);
      chk({tag, "_done"}, {95'd0, Load_Done}, 96'd0);
      chk({tag, "_err"}, {95'd0, Load_Err}, 96'd0);
   endtask

   initial begin
      int len, base, sel, prob;
      repeat (3) @(negedge Clk);
      chk_all_zero("reset");
      Resetn = 1'b1;
      @(negedge Clk);

      // Directed packing example with hand-computed instructions.
      words = '{32'h11111111, 32'h22222222, 32'h000000AB,
                32'h33333333, 32'h44444444, 32'hFFFFFFCD};
      seen.delete();
      do_load(0, 2, 1, 100, 0);
      chk("dir_nwrites", 96'(seen.size()), 96'd2);
      if (seen.size() >= 2) begin
         chk("dir_en0", {92'd0, seen[0].en}, 96'h2);
         chk("dir_addr0", {86'd0, seen[0].addr}, 96'd0);
         chk("dir_data0", {24'd0, seen[0].data}, 96'hAB_22222222_11111111);
         chk("dir_en1", {92'd0, seen[1].en}, 96'h2);
         chk("dir_addr1", {86'd0, seen[1].addr}, 96'd1);
         chk("dir_data1", {24'd0, seen[1].data}, 96'hCD_44444444_33333333);
      end

      // Broadcast, back-to-back with the previous load.
      seen.delete();
      do_load(5, 1, 4, 100, 0);
      chk("bcast_nwrites", 96'(seen.size()), 96'd1);
      if (seen.size() >= 1) chk("bcast_en", {92'd0, seen[0].en}, 96'hF);

      do_err(1020, 5, 0, 1'b0);
      do_err(10, 0, 0, 1'b0);
      do_err(0, 1, 5, 1'b0);
      do_err(0, 1, 0, 1'b1);
      do_err(0, 1, 7, 1'b0);

      // Last address of memory, and an exactly-fitting range.
      seen.delete();
      do_load(1023, 1, 3, 100, 0);
      chk("edge_nwrites", 96'(seen.size()), 96'd1);
      if (seen.size() >= 1) chk("edge_addr", {86'd0, seen[0].addr}, 96'd1023);
      do_load(1020, 4, 0, 100, 0);

      seen.delete();
      do_load(200, 3, 2, 50, 0);
      chk("toggle_nwrites", 96'(seen.size()), 96'd3);

      for (int k = 0; k < 10; k++) begin
         len  = $urandom_range(1, 5);
         base = ($urandom_range(0, 3) == 0) ? 1024 - len : $urandom_range(0, 1024 - len);
         sel  = $urandom_range(0, NPE);
         prob = ($urandom_range(0, 1) == 0) ? 100 : $urandom_range(20, 90);
         do_load(base, len, sel, prob, 0);
         if ($urandom_range(0, 2) == 0)
            do_err($urandom_range(1020, 1023), $urandom_range(6, 40), 0, 1'b0);
      end

      // Reset after beat 1 of the second instruction.
      do_load(100, 2, 2, 100, 5);
      @(negedge Clk);
      #1 Resetn = 1'b0;
      #1 chk_all_zero("async_reset");
      @(negedge Clk);
      Resetn = 1'b1;
      @(negedge Clk);
      chk("partial_not_written", 96'(exp_q.size()), 96'd0);
      exp_q.delete();
      seen.delete();
      do_load(0, 1, 0, 100, 0);
      chk("after_reset_nwrites", 96'(seen.size()), 96'd1);

      repeat (3) @(negedge Clk);
      chk("model_drained", 96'(exp_q.size()), 96'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
